// File: rtl/match_ctl.sv
// Air-hockey match sequencer: serve hold, play enable, goal detection, scoring and win.
// Owns the ball datapath's centre-reload (ball_hold) and motion qualifier (ball_en).
module match_ctl #(
  parameter int unsigned GOAL_LEFT_X  = 40,
  parameter int unsigned GOAL_RIGHT_X = 984,
  parameter int unsigned GOAL_Y_MIN   = 300,
  parameter int unsigned GOAL_Y_MAX   = 468,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned GOAL_FRAMES  = 120,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  output logic        ball_hold,
  output logic        ball_en,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic [2:0]  game_state,
  output logic        last_scorer,
  output logic        game_over
);

  localparam int unsigned PW  = 12;
  localparam int unsigned SW  = 4;
  localparam int unsigned CW  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_p1, r_p2, w_p1_nxt, w_p2_nxt;
  logic            r_last, w_last_nxt;
  logic            r_hold, w_hold_nxt;
  logic            r_en, w_en_nxt;
  logic            r_over, w_over_nxt;
  logic            r_start_q;
  logic            w_start_rise;
  logic            w_in_mouth, w_goal_l, w_goal_r;
  logic            w_serve_done, w_goal_done, w_win;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_in_mouth   = (ypos_ball >= PW'(GOAL_Y_MIN)) && (ypos_ball <= PW'(GOAL_Y_MAX));
  assign w_goal_l     = w_in_mouth && (xpos_ball <= PW'(GOAL_LEFT_X));
  assign w_goal_r     = w_in_mouth && (xpos_ball >= PW'(GOAL_RIGHT_X));
  assign w_serve_done = frame_tick && (r_cnt == CW'(SERVE_FRAMES - 1));
  assign w_goal_done  = frame_tick && (r_cnt == CW'(GOAL_FRAMES - 1));
  assign w_win        = (r_p1 == SW'(WIN_SCORE)) || (r_p2 == SW'(WIN_SCORE));

  // Next state and score updates
  always_comb begin
    w_state_nxt = r_state;
    w_p1_nxt    = r_p1;
    w_p2_nxt    = r_p2;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_p1_nxt    = '0;
          w_p2_nxt    = '0;
          w_state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (w_serve_done) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // Left goal wins a tie; it can only happen with overlapping goal bounds
        if (w_goal_l) begin
          w_p2_nxt    = (r_p2 == 4'hF) ? r_p2 : r_p2 + 4'd1;
          w_last_nxt  = 1'b1;
          w_state_nxt = ST_GOAL;
        end else if (w_goal_r) begin
          w_p1_nxt    = (r_p1 == 4'hF) ? r_p1 : r_p1 + 4'd1;
          w_last_nxt  = 1'b0;
          w_state_nxt = ST_GOAL;
        end
      end
      ST_GOAL: begin
        if (w_goal_done) w_state_nxt = w_win ? ST_OVER : ST_SERVE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_p1_nxt    = '0;
        w_p2_nxt    = '0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // Output decode of the upcoming state, registered alongside it
  always_comb begin
    w_hold_nxt = 1'b1;
    w_en_nxt   = 1'b0;
    w_over_nxt = 1'b0;
    case (w_state_nxt)
      ST_PLAY: begin
        w_hold_nxt = 1'b0;
        w_en_nxt   = 1'b1;
      end
      ST_GOAL: w_hold_nxt = 1'b0;
      ST_OVER: w_over_nxt = 1'b1;
      default: w_hold_nxt = 1'b1;
    endcase
  end

  // Frame counter restarts on every state change and saturates
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (frame_tick && (r_cnt != 8'hFF)) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_last    <= 1'b0;
      r_hold    <= 1'b1;
      r_en      <= 1'b0;
      r_over    <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_p1      <= w_p1_nxt;
      r_p2      <= w_p2_nxt;
      r_last    <= w_last_nxt;
      r_hold    <= w_hold_nxt;
      r_en      <= w_en_nxt;
      r_over    <= w_over_nxt;
      r_start_q <= start_btn;
    end
  end

  assign ball_hold   = r_hold;
  assign ball_en     = r_en;
  assign score_p1    = r_p1;
  assign score_p2    = r_p2;
  assign game_state  = r_state;
  assign last_scorer = r_last;
  assign game_over   = r_over;

endmodule

// File: tb/tb_match_ctl.sv
// Self-checking bench for match_ctl: vector tables plus scripted match sequences.
module tb_match_ctl;

  localparam int CX = 512;
  localparam int CY = 384;

  logic        clk_in = 1'b0;
  logic        rst, frame_tick, start_btn;
  logic [11:0] xpos_ball, ypos_ball;
  logic        ball_hold, ball_en, last_scorer, game_over;
  logic [3:0]  score_p1, score_p2;
  logic [2:0]  game_state;

  always #5 clk_in = ~clk_in;

  match_ctl dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .xpos_ball   (xpos_ball),
    .ypos_ball   (ypos_ball),
    .ball_hold   (ball_hold),
    .ball_en     (ball_en),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .game_state  (game_state),
    .last_scorer (last_scorer),
    .game_over   (game_over)
  );

  typedef struct {
    string name;
    int r, t, s, x, y, st, p1, p2, last;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic        hold, en, over, last;
    logic [3:0]  p1, p2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_p1 = 0, m_p2 = 0, m_last = 0;

  function automatic vec_t V(input string n, input int r, t, s, x, y, st, p1, p2, last);
    vec_t v;
    v.name = n; v.r = r; v.t = t; v.s = s; v.x = x; v.y = y;
    v.st = st; v.p1 = p1; v.p2 = p2; v.last = last;
    return v;
  endfunction

  function automatic vec_t M(input string n, input int t, s, x, y, st);
    return V(n, 0, t, s, x, y, st, m_p1, m_p2, m_last);
  endfunction

  // Drive one cycle; optionally queue an expectation and compare after the edge
  task automatic step(input vec_t v, input bit chk);
    exp_t e;
    @(negedge clk_in);
    rst        = 1'(v.r);
    frame_tick = 1'(v.t);
    start_btn  = 1'(v.s);
    xpos_ball  = 12'(v.x);
    ypos_ball  = 12'(v.y);
    if (chk) begin
      e.name = v.name;
      e.st   = 3'(v.st);
      e.hold = (v.st == 0) || (v.st == 1) || (v.st == 4);
      e.en   = (v.st == 2);
      e.over = (v.st == 4);
      e.p1   = 4'(v.p1);
      e.p2   = 4'(v.p2);
      e.last = 1'(v.last);
      sb.push_back(e);
    end
    @(posedge clk_in);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({game_state, ball_hold, ball_en, game_over, score_p1, score_p2, last_scorer} !==
          {e.st, e.hold, e.en, e.over, e.p1, e.p2, e.last}) begin
        errors++;
        $display("FAIL %s: got st=%0d hold=%0b en=%0b over=%0b p1=%0d p2=%0d last=%0b, want st=%0d hold=%0b en=%0b over=%0b p1=%0d p2=%0d last=%0b",
                 e.name, game_state, ball_hold, ball_en, game_over, score_p1, score_p2, last_scorer,
                 e.st, e.hold, e.en, e.over, e.p1, e.p2, e.last);
      end
    end
  endtask

  // 120-frame freeze after a goal; exit depends on whether someone reached 7
  task automatic freeze(input int s);
    int nxt;
    for (int i = 0; i < 118; i++) step(M("freeze", 1, s, CX, CY, 3), 0);
    step(M("goal_hold_119", 1, s, CX, CY, 3), 1);
    nxt = (m_p1 == 7 || m_p2 == 7) ? 4 : 1;
    step(M("goal_exit", 1, s, CX, CY, nxt), 1);
  endtask

  // 60-frame serve; with big set, long tick-free gaps must not advance the count
  task automatic serve(input bit big);
    for (int i = 0; i < 58; i++) begin
      if (big && i < 3)
        for (int j = 0; j < 1000; j++) step(M("serve_gap", 0, 0, CX, CY, 1), 0);
      step(M("serve_tick", 1, 0, CX, CY, 1), 0);
    end
    step(M("serve_59", 1, 0, CX, CY, 1), 1);
    step(M("serve_exit", 1, 0, CX, CY, 2), 1);
  endtask

  task automatic goal(input bit left);
    if (left) begin
      m_p2++; m_last = 1;
      step(M("goal_left", 0, 0, 40, 384, 3), 1);
    end else begin
      m_p1++; m_last = 0;
      step(M("goal_right", 0, 0, 984, 384, 3), 1);
    end
  endtask

  vec_t tbl1[6];
  vec_t tbl2[5];

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0;
    xpos_ball = 12'(CX); ypos_ball = 12'(CY);

    tbl1[0] = '{"rst_0",      1, 0, 0, CX, CY, 0, 0, 0, 0};
    tbl1[1] = '{"rst_1",      1, 0, 0, CX, CY, 0, 0, 0, 0};
    tbl1[2] = '{"idle",       0, 0, 0, CX, CY, 0, 0, 0, 0};
    tbl1[3] = '{"start_rise", 0, 0, 1, CX, CY, 1, 0, 0, 0};
    tbl1[4] = '{"start_held", 0, 0, 1, CX, CY, 1, 0, 0, 0};
    tbl1[5] = '{"serve_tick1",0, 1, 0, CX, CY, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) step(tbl1[i], 1);

    for (int i = 0; i < 57; i++) step(V("serve", 0, 1, 0, CX, CY, 1, 0, 0, 0), 0);
    step(V("serve_59", 0, 1, 0, CX, CY, 1, 0, 0, 0), 1);
    step(V("play_entry", 0, 1, 0, CX, CY, 2, 0, 0, 0), 1);

    tbl2[0] = '{"play_centre",  0, 0, 1, CX,  CY,  2, 0, 0, 0};
    tbl2[1] = '{"right_y299",   0, 0, 0, 984, 299, 2, 0, 0, 0};
    tbl2[2] = '{"left_y469",    0, 0, 0, 40,  469, 2, 0, 0, 0};
    tbl2[3] = '{"left_x41",     0, 0, 0, 41,  384, 2, 0, 0, 0};
    tbl2[4] = '{"left_goal",    0, 0, 0, 40,  384, 3, 0, 1, 1};
    for (int i = 0; i < 5; i++) step(tbl2[i], 1);
    m_p2 = 1; m_last = 1;

    for (int i = 0; i < 10; i++) step(M("goal_once", 0, 0, 40, 384, 3), 1);
    freeze(0);
    serve(1);

    m_p1 = 1; m_last = 0;
    step(M("right_y300", 0, 0, 984, 300, 3), 1);
    freeze(0);
    serve(0);

    for (int k = 0; k < 6; k++) begin
      goal(0);
      if (k < 5) begin
        freeze(0);
        serve(0);
      end
    end
    freeze(1);
    for (int i = 0; i < 5; i++) step(M("over_btn_held", 0, 1, CX, CY, 4), 1);
    step(M("over_release", 0, 0, CX, CY, 4), 1);
    m_p1 = 0; m_p2 = 0;
    step(M("over_restart", 0, 1, CX, CY, 1), 1);
    serve(0);

    for (int k = 0; k < 8; k++) begin
      goal(k < 5);
      freeze(0);
      serve(0);
    end
    step(M("play_3_5", 0, 0, CX, CY, 2), 1);

    m_p1 = 0; m_p2 = 0; m_last = 0;
    step(V("rst_mid_play", 1, 0, 0, CX, CY, 0, 0, 0, 0), 1);
    step(V("after_rst",    0, 0, 0, CX, CY, 0, 0, 0, 0), 1);
    step(V("idle_start_tick", 0, 1, 1, CX, CY, 1, 0, 0, 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
